// File: rtl/btn_led_pkg.sv
// Shared types and constants for the button/LED controller: mode encoding,
// mode sequencing and the default load pattern.
package btn_led_pkg;

  typedef enum logic [1:0] {
    BLINK = 2'd0,
    COUNT = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } mode_e;

  localparam logic [5:0] DEFAULT_PRESET = 6'b010101;

  // Button slots in the raw/debounced vectors
  localparam int NUM_BTN  = 3;
  localparam int BTN_LOAD = 0;
  localparam int BTN_INC  = 1;
  localparam int BTN_MODE = 2;

  function automatic mode_e mode_next(input mode_e m);
    case (m)
      BLINK:   return COUNT;
      COUNT:   return SHIFT;
      SHIFT:   return HOLD;
      HOLD:    return BLINK;
      default: return BLINK;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low push-button debouncer: 2-flop synchroniser, stability counter,
// debounced level and a one-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 270000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pressed_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Synchroniser resets to "released" so a held button is seen as a fresh press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], btn_n};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != state_q) begin
      if (cnt_q == CNT_MAX) begin
        state_d = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign pressed_n = state_q;
  assign press     = press_q;

endmodule

// File: rtl/btn_led_ctrl.sv
// Button/LED controller: three debounced buttons drive a 4-mode LED pattern
// on a periodic tick, plus a divided probe clock. BTN_AUTOREPEAT_EN adds inc auto-repeat.
module btn_led_ctrl
  import btn_led_pkg::*;
#(
  parameter int               LED_W        = 6,
  parameter int               WAIT_TIME    = 13500000,
  parameter int               DEBOUNCE_CYC = 270000,
  parameter int               DIV_HALF     = 13,
  parameter logic [LED_W-1:0] PRESET       = LED_W'(DEFAULT_PRESET),
  parameter int               REPEAT_CYC   = 13500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_load_n,
  input  logic             btn_inc_n,
  input  logic             btn_mode_n,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode,
  output logic             div_clk
);

  localparam int TW = (WAIT_TIME > 0) ? $clog2(WAIT_TIME + 1) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(WAIT_TIME);
  localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV_HALF - 1);

  logic [NUM_BTN-1:0] btn_raw, press_w, pressed_n_w;
  logic               inc_evt;
  logic               unused_ok;

  mode_e            mode_q, mode_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic             tick;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             div_q, div_d;

  assign btn_raw = {btn_mode_n, btn_inc_n, btn_load_n};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_n     (btn_raw[i]),
      .pressed_n (pressed_n_w[i]),
      .press     (press_w[i])
    );
  end

  assign unused_ok = ^{pressed_n_w, REPEAT_CYC[0]};

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYC - 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_q, rep_d;

  // Counts only while inc is held; release drops the count back to zero
  always_comb begin
    rep_cnt_d = '0;
    rep_d     = 1'b0;
    if (!pressed_n_w[BTN_INC]) begin
      if (rep_cnt_q == REP_MAX) rep_d = 1'b1;
      else                      rep_cnt_d = rep_cnt_q + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q <= '0;
      rep_q     <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_q     <= rep_d;
    end
  end

  assign inc_evt = press_w[BTN_INC] | rep_q;
`else
  assign inc_evt = press_w[BTN_INC];
`endif

  assign tick = (tick_q == TICK_MAX);

  always_comb begin
    mode_d = mode_q;
    if (press_w[BTN_MODE]) mode_d = mode_next(mode_q);
  end

  // Load beats inc beats tick; a button event also restarts the tick period
  always_comb begin
    led_d  = led_q;
    tick_d = tick ? '0 : tick_q + TW'(1);
    if (press_w[BTN_LOAD]) begin
      led_d  = PRESET;
      tick_d = '0;
    end else if (inc_evt) begin
      led_d  = led_q + LED_W'(1);
      tick_d = '0;
    end else if (tick) begin
      case (mode_q)
        BLINK:   led_d = ~led_q;
        COUNT:   led_d = led_q + LED_W'(1);
        SHIFT:   led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
        HOLD:    led_d = led_q;
        default: led_d = led_q;
      endcase
    end
  end

  always_comb begin
    div_cnt_d = div_cnt_q + DW'(1);
    div_d     = div_q;
    if (div_cnt_q == DIV_MAX) begin
      div_cnt_d = '0;
      div_d     = ~div_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= BLINK;
      led_q     <= '0;
      tick_q    <= '0;
      div_cnt_q <= '0;
      div_q     <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      led_q     <= led_d;
      tick_q    <= tick_d;
      div_cnt_q <= div_cnt_d;
      div_q     <= div_d;
    end
  end

  assign led     = led_q;
  assign mode    = mode_q;
  assign div_clk = div_q;

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Scoreboard bench for btn_led_ctrl with small timing parameters: expected
// led/mode/div_clk values are queued at stimulus time and checked at their cycle.
module tb_btn_led_ctrl;

  localparam int S_LED  = 0;
  localparam int S_MODE = 1;
  localparam int S_DIV  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_load_n = 1'b1;
  logic       btn_inc_n  = 1'b1;
  logic       btn_mode_n = 1'b1;
  logic [5:0] led;
  logic [1:0] mode;
  logic       div_clk;

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb_q[$];
  exp_t keep_q[$];
  int   cyc;
  int   checks   = 0;
  int   failures = 0;

  btn_led_ctrl #(
    .LED_W        (6),
    .WAIT_TIME    (9),
    .DEBOUNCE_CYC (4),
    .DIV_HALF     (3),
    .PRESET       (6'b010101),
    .REPEAT_CYC   (1000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_load_n (btn_load_n),
    .btn_inc_n  (btn_inc_n),
    .btn_mode_n (btn_mode_n),
    .led        (led),
    .mode       (mode),
    .div_clk    (div_clk)
  );

  always #5 clk = ~clk;

  // Cycle index: number of rising edges since the last reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic exp_at(input int c, input int s, input logic [7:0] v);
    exp_t e;
    e.cyc = c;
    e.sel = s;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      keep_q.delete();
      foreach (sb_q[i]) begin
        if (sb_q[i].cyc == cyc) begin
          case (sb_q[i].sel)
            S_LED:   chk($sformatf("led@%0d", cyc), {2'b00, led}, sb_q[i].val);
            S_MODE:  chk($sformatf("mode@%0d", cyc), {6'b0, mode}, sb_q[i].val);
            default: chk($sformatf("div@%0d", cyc), {7'b0, div_clk}, sb_q[i].val);
          endcase
        end else if (sb_q[i].cyc < cyc) begin
          chk("sb_late", 8'(cyc), 8'(sb_q[i].cyc));
        end else begin
          keep_q.push_back(sb_q[i]);
        end
      end
      sb_q = keep_q;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: cyc=%0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_led",  {2'b00, led},   8'h00);
    chk("rst_mode", {6'b0, mode},   8'h00);
    chk("rst_div",  {7'b0, div_clk}, 8'h00);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Idle blink and divider phase
    exp_at(9, S_LED, 8'h00);  exp_at(10, S_LED, 8'h3F);
    exp_at(19, S_LED, 8'h3F); exp_at(20, S_LED, 8'h00);
    exp_at(29, S_LED, 8'h00); exp_at(30, S_LED, 8'h3F);
    exp_at(2, S_DIV, 8'h0);   exp_at(3, S_DIV, 8'h1);
    exp_at(5, S_DIV, 8'h1);   exp_at(6, S_DIV, 8'h0);
    exp_at(8, S_DIV, 8'h0);   exp_at(9, S_DIV, 8'h1);

    // Load: effect at N+7, tick restarts so next blink is 10 cycles later
    wait_cyc(32); btn_load_n = 1'b0;
    exp_at(38, S_LED, 8'h3F); exp_at(39, S_LED, 8'h15);
    exp_at(48, S_LED, 8'h15); exp_at(49, S_LED, 8'h2A);
    wait_cyc(44); btn_load_n = 1'b1;

    // 3-cycle glitch on inc is ignored
    wait_cyc(50); btn_inc_n = 1'b0;
    exp_at(58, S_LED, 8'h2A); exp_at(59, S_LED, 8'h15);
    wait_cyc(53); btn_inc_n = 1'b1;

    // Long inc hold gives exactly one increment
    wait_cyc(60); btn_inc_n = 1'b0;
    exp_at(66, S_LED, 8'h15); exp_at(67, S_LED, 8'h16);
    exp_at(76, S_LED, 8'h16); exp_at(77, S_LED, 8'h29);
    wait_cyc(70); btn_inc_n = 1'b1;

    // Three mode presses walk BLINK->COUNT->SHIFT->HOLD across ticks
    exp_at(86, S_LED, 8'h29);  exp_at(87, S_LED, 8'h16);
    exp_at(97, S_LED, 8'h17);  exp_at(107, S_LED, 8'h2E);
    exp_at(117, S_LED, 8'h1D); exp_at(120, S_LED, 8'h1D);
    exp_at(170, S_LED, 8'h1D);
    for (int k = 0; k < 3; k++) begin
      wait_cyc(80 + 16 * k); btn_mode_n = 1'b0;
      exp_at(86 + 16 * k, S_MODE, 8'(k));
      exp_at(87 + 16 * k, S_MODE, 8'(k + 1));
      wait_cyc(88 + 16 * k); btn_mode_n = 1'b1;
    end

    // Fourth press wraps to BLINK; blinking resumes at the next tick
    wait_cyc(172); btn_mode_n = 1'b0;
    exp_at(178, S_MODE, 8'h3); exp_at(179, S_MODE, 8'h0);
    exp_at(186, S_LED, 8'h1D); exp_at(187, S_LED, 8'h22);
    wait_cyc(180); btn_mode_n = 1'b1;

    // Load and inc in the same cycle, coinciding with a tick: load only
    wait_cyc(190); btn_load_n = 1'b0; btn_inc_n = 1'b0;
    exp_at(196, S_LED, 8'h22); exp_at(197, S_LED, 8'h15);
    exp_at(206, S_LED, 8'h15); exp_at(207, S_LED, 8'h2A);
    wait_cyc(200); btn_load_n = 1'b1; btn_inc_n = 1'b1;

    // Reset in the middle of a load debounce
    wait_cyc(210); btn_load_n = 1'b0;
    wait_cyc(213);
    chk("sb_drain", 8'(sb_q.size()), 8'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led",  {2'b00, led},    8'h00);
    chk("arst_mode", {6'b0, mode},    8'h00);
    chk("arst_div",  {7'b0, div_clk}, 8'h00);
    btn_load_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // No stale press after release; COUNT wrap from 3F, then SHIFT from 15
    exp_at(5, S_LED, 8'h00); exp_at(9, S_LED, 8'h00); exp_at(10, S_LED, 8'h3F);
    wait_cyc(5); btn_mode_n = 1'b0;
    exp_at(11, S_MODE, 8'h0); exp_at(12, S_MODE, 8'h1);
    exp_at(19, S_LED, 8'h3F); exp_at(20, S_LED, 8'h00); exp_at(30, S_LED, 8'h01);
    wait_cyc(13); btn_mode_n = 1'b1;

    wait_cyc(31); btn_mode_n = 1'b0;
    exp_at(37, S_MODE, 8'h1); exp_at(38, S_MODE, 8'h2); exp_at(40, S_LED, 8'h02);
    wait_cyc(39); btn_mode_n = 1'b1;

    wait_cyc(42); btn_load_n = 1'b0;
    exp_at(48, S_LED, 8'h02); exp_at(49, S_LED, 8'h15);
    exp_at(58, S_LED, 8'h15); exp_at(59, S_LED, 8'h2A);
    exp_at(69, S_LED, 8'h15);
    wait_cyc(50); btn_load_n = 1'b1;

    wait_cyc(75);
    chk("sb_end", 8'(sb_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
